// File: rtl/ps2_host_tx_pkg.sv
// Shared types, register offsets, status bit positions and timing helpers for the PS/2 host transmitter.
// Status bit positions must match what software and the mmapper decode.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_WAIT1,
    ST_SHIFT,
    ST_RELEASE
  } state_t;

  typedef struct packed {
    logic overrun;
    logic timeout;
    logic nack;
    logic done;
    logic busy;
  } status_t;

  localparam logic [2:0] OFF_DATA   = 3'd0;
  localparam logic [2:0] OFF_STATUS = 3'd1;
  localparam logic [2:0] OFF_CTRL   = 3'd2;

  localparam int BIT_DONE    = 1;
  localparam int BIT_NACK    = 2;
  localparam int BIT_TIMEOUT = 3;
  localparam int BIT_OVERRUN = 4;

  // Microseconds to clock cycles, never below one cycle.
  function automatic int us_to_cyc(input int freq, input int us);
    int cyc;
    cyc = freq / 1000 * us / 1000;
    return (cyc < 1) ? 1 : cyc;
  endfunction

  function automatic int max_int(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one PS/2 line plus a one-cycle falling-edge pulse; 2-3 cycles latency.
// No backpressure: free-running, idles high like the bus.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic line_sync,
  output logic line_fall
);

  logic meta;
  logic prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta      <= 1'b1;
      line_sync <= 1'b1;
      prev      <= 1'b1;
    end else begin
      meta      <= line_in;
      line_sync <= meta;
      prev      <= line_sync;
    end
  end

  assign line_fall = prev & ~line_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: one CPU-written byte per frame, inhibit, request-to-send, shift, ACK check.
// Latency is set by the device clock; writes while busy are dropped and flagged as overrun.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int CLOCK_FREQ       = 62500000,
  parameter int INHIBIT_US       = 120,
  parameter int START_TIMEOUT_US = 15000,
  parameter int FRAME_TIMEOUT_US = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  a,
  input  logic [31:0] d,
  input  logic        we,
  output logic [31:0] spo,
  output logic        irq,
  output logic        rx_inhibit,
  input  logic        ps2_clk_in,
  input  logic        ps2_data_in,
  output logic        ps2_clk_oe,
  output logic        ps2_data_oe
);

  localparam int INHIBIT_CYC       = us_to_cyc(CLOCK_FREQ, INHIBIT_US);
  localparam int HOLD_CYC          = us_to_cyc(CLOCK_FREQ, 1);
  localparam int START_TIMEOUT_CYC = us_to_cyc(CLOCK_FREQ, START_TIMEOUT_US);
  localparam int FRAME_TIMEOUT_CYC = us_to_cyc(CLOCK_FREQ, FRAME_TIMEOUT_US);
  localparam int MAX_CYC = max_int(max_int(INHIBIT_CYC, HOLD_CYC),
                                   max_int(START_TIMEOUT_CYC, FRAME_TIMEOUT_CYC));
  localparam int CNT_W = $clog2(MAX_CYC + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t INHIBIT_LD = cnt_t'(INHIBIT_CYC);
  localparam cnt_t HOLD_LD    = cnt_t'(HOLD_CYC);
  localparam cnt_t START_LD   = cnt_t'(START_TIMEOUT_CYC);
  localparam cnt_t FRAME_LD   = cnt_t'(FRAME_TIMEOUT_CYC);
  localparam cnt_t CNT_ONE    = cnt_t'(1);

  state_t      state;
  state_t      state_nxt;
  status_t     sts;
  cnt_t        cnt;
  cnt_t        cnt_ld_val;
  logic        cnt_ld;
  logic [3:0]  bitcnt;
  logic [7:0]  tx_byte;
  logic        tx_parity;
  logic        irq_en;
  logic        clk_sync;
  logic        clk_fall;
  logic        data_sync;
  logic        unused_data_fall;
  logic        wr_data;
  logic        wr_status;
  logic        wr_ctrl;
  logic        accept;
  logic        cnt_one;
  logic        expire;
  logic        last_edge;
  logic        frame_end;
  logic        unused_ok;

  ps2_line_sync u_clk_sync (
    .clk       (clk),
    .rst       (rst),
    .line_in   (ps2_clk_in),
    .line_sync (clk_sync),
    .line_fall (clk_fall)
  );

  ps2_line_sync u_data_sync (
    .clk       (clk),
    .rst       (rst),
    .line_in   (ps2_data_in),
    .line_sync (data_sync),
    .line_fall (unused_data_fall)
  );

  assign wr_data   = we && (a == OFF_DATA);
  assign wr_status = we && (a == OFF_STATUS);
  assign wr_ctrl   = we && (a == OFF_CTRL);
  assign accept    = wr_data && (state == ST_IDLE);
  assign cnt_one   = (cnt == CNT_ONE);
  // One shared counter: only the device-driven states treat expiry as a timeout.
  assign expire    = cnt_one && ((state == ST_WAIT1) || (state == ST_SHIFT) || (state == ST_RELEASE));
  assign last_edge = (state == ST_SHIFT) && clk_fall && (bitcnt == 4'd10) && !expire;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (wr_data) state_nxt = ST_INHIBIT;
      ST_INHIBIT: if (cnt_one) state_nxt = ST_REQ;
      ST_REQ:     if (cnt_one) state_nxt = ST_WAIT1;
      ST_WAIT1: begin
        if (expire)        state_nxt = ST_IDLE;
        else if (clk_fall) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (expire)         state_nxt = ST_IDLE;
        else if (last_edge) state_nxt = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (expire || (clk_sync && data_sync)) state_nxt = ST_IDLE;
      end
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ps2_clk_oe = 1'b0;
    cnt_ld     = 1'b0;
    cnt_ld_val = '0;
    frame_end  = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_ld     = wr_data;
        cnt_ld_val = INHIBIT_LD;
      end
      ST_INHIBIT: begin
        ps2_clk_oe = 1'b1;
        cnt_ld     = cnt_one;
        cnt_ld_val = HOLD_LD;
      end
      ST_REQ: begin
        ps2_clk_oe = 1'b1;
        cnt_ld     = cnt_one;
        cnt_ld_val = START_LD;
      end
      ST_WAIT1: begin
        cnt_ld     = clk_fall && !expire;
        cnt_ld_val = FRAME_LD;
        frame_end  = expire;
      end
      ST_SHIFT:   frame_end = expire;
      ST_RELEASE: frame_end = expire || (clk_sync && data_sync);
      default:    frame_end = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      bitcnt      <= 4'd0;
      tx_byte     <= 8'd0;
      tx_parity   <= 1'b0;
      ps2_data_oe <= 1'b0;
    end else begin
      if (cnt_ld) begin
        cnt <= cnt_ld_val;
      end else if (cnt != '0) begin
        cnt <= cnt - CNT_ONE;
      end

      if (accept) begin
        tx_byte   <= d[7:0];
        tx_parity <= odd_parity(d[7:0]);
      end

      // ps2_data_oe drives the pad low, so a '1' bit is sent by releasing the line.
      if (frame_end) begin
        ps2_data_oe <= 1'b0;
      end else begin
        case (state)
          ST_INHIBIT: if (cnt_one) ps2_data_oe <= 1'b1;
          ST_WAIT1: begin
            if (clk_fall) begin
              ps2_data_oe <= ~tx_byte[0];
              bitcnt      <= 4'd1;
            end
          end
          ST_SHIFT: begin
            if (clk_fall) begin
              if (bitcnt <= 4'd7)      ps2_data_oe <= ~tx_byte[bitcnt[2:0]];
              else if (bitcnt == 4'd8) ps2_data_oe <= ~tx_parity;
              else                     ps2_data_oe <= 1'b0;
              bitcnt <= bitcnt + 4'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // A hardware set in the same cycle as a write-1-to-clear keeps the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sts    <= '0;
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (accept)         sts.busy <= 1'b1;
      else if (frame_end) sts.busy <= 1'b0;
      sts.done    <= frame_end | (sts.done & ~(wr_status & d[BIT_DONE]));
      sts.nack    <= (last_edge & data_sync) | (sts.nack & ~(wr_status & d[BIT_NACK]));
      sts.timeout <= expire | (sts.timeout & ~(wr_status & d[BIT_TIMEOUT]));
      sts.overrun <= (wr_data & sts.busy) | (sts.overrun & ~(wr_status & d[BIT_OVERRUN]));
      if (wr_ctrl) irq_en <= d[0];
      irq <= irq_en & sts.done;
    end
  end

  always_comb begin
    spo = 32'd0;
    case (a)
      OFF_DATA:   spo = {24'd0, tx_byte};
      OFF_STATUS: spo = {27'd0, sts};
      OFF_CTRL:   spo = {31'd0, irq_en};
      default:    spo = 32'd0;
    endcase
  end

  assign rx_inhibit = sts.busy;
  assign unused_ok  = ^{d[31:8], unused_data_fall};

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the DUT; frame bits and end-of-frame
// status are predicted from the byte and device behaviour and checked by independent monitors.
module tb_ps2_host_tx;

  localparam int CF       = 1000000;
  localparam int DEV_HALF = 40;
  localparam int M_ACK    = 0;
  localparam int M_NACK   = 1;
  localparam int M_SILENT = 2;

  typedef struct {
    logic [4:0] status;
    logic       irq;
  } exp_end_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  a = 3'd1;
  logic [31:0] d = 32'd0;
  logic        we = 1'b0;
  logic [31:0] spo;
  logic        irq;
  logic        rx_inhibit;
  logic        ps2_clk_oe;
  logic        ps2_data_oe;
  logic        dev_clk_low = 1'b0;
  logic        dev_data_low = 1'b0;
  logic        ps2_clk_line;
  logic        ps2_data_line;

  int          n_pass = 0;
  int          n_total = 0;
  logic [9:0]  exp_bits_q[$];
  exp_end_t    exp_end_q[$];
  int          dev_mode = M_ACK;
  bit          dev_abort = 1'b0;
  bit          dev_busy = 1'b0;
  int          dev_edge = 0;
  bit          m_irq_en = 1'b0;
  bit          mon_prev_busy = 1'b0;

  assign ps2_clk_line  = ~ps2_clk_oe & ~dev_clk_low;
  assign ps2_data_line = ~ps2_data_oe & ~dev_data_low;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .CLOCK_FREQ       (CF),
    .INHIBIT_US       (120),
    .START_TIMEOUT_US (15000),
    .FRAME_TIMEOUT_US (2000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .a           (a),
    .d           (d),
    .we          (we),
    .spo         (spo),
    .irq         (irq),
    .rx_inhibit  (rx_inhibit),
    .ps2_clk_in  (ps2_clk_line),
    .ps2_data_in (ps2_data_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic fail(input string name);
    n_total++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Reference frame as the device sees it: 8 data bits LSB first, odd parity, stop = 1.
  function automatic logic [9:0] frame_bits(input logic [7:0] b);
    logic [9:0] r;
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      r[i] = b[i];
      ones += int'(b[i]);
    end
    r[8] = ((ones % 2) == 0);
    r[9] = 1'b1;
    return r;
  endfunction

  // Device model: answers a request-to-send with 11 clocks, samples on rising edges.
  initial begin : device
    logic [9:0] cap;
    logic [9:0] expb;
    bit aborted;
    forever begin
      @(negedge clk);
      if (rst && dev_mode != M_SILENT && ps2_clk_line && !ps2_data_line) begin
        dev_busy = 1'b1;
        aborted  = 1'b0;
        cap      = '0;
        repeat (30) @(negedge clk);
        for (int e = 1; e <= 11 && !aborted; e++) begin
          dev_clk_low = 1'b1;
          dev_edge    = e;
          repeat (DEV_HALF) @(negedge clk);
          dev_clk_low = 1'b0;
          if (e <= 10) cap[e-1] = ps2_data_line;
          repeat (DEV_HALF / 2) @(negedge clk);
          if (e == 10 && dev_mode == M_ACK) dev_data_low = 1'b1;
          repeat (DEV_HALF / 2) @(negedge clk);
          if (e == 11) dev_data_low = 1'b0;
          if (dev_abort) aborted = 1'b1;
        end
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        if (!aborted) begin
          if (exp_bits_q.size() == 0) fail("frame_unexpected");
          else begin
            expb = exp_bits_q.pop_front();
            check("frame_bits", 32'(cap), 32'(expb));
          end
        end
        dev_busy = 1'b0;
      end
    end
  end

  // End-of-frame monitor: busy falling means the DUT has reported a result.
  initial begin : status_mon
    exp_end_t ex;
    forever begin
      @(negedge clk);
      if (!rst) mon_prev_busy = 1'b0;
      else begin
        if (mon_prev_busy && !rx_inhibit) begin
          if (exp_end_q.size() == 0) fail("end_unexpected");
          else begin
            ex = exp_end_q.pop_front();
            check("status", spo, {27'd0, ex.status});
            check("lines_released", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
            @(negedge clk);
            check("irq", 32'(irq), 32'(ex.irq));
          end
        end
        mon_prev_busy = rx_inhibit;
      end
    end
  end

  task automatic wr(input logic [2:0] aa, input logic [31:0] dd);
    @(negedge clk);
    a = aa; d = dd; we = 1'b1;
    @(negedge clk);
    we = 1'b0; a = 3'd1; d = 32'd0;
  endtask

  task automatic rd_check(input string name, input logic [2:0] aa, input logic [31:0] exp);
    @(negedge clk);
    a = aa;
    #1;
    check(name, spo, exp);
    a = 3'd1;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (rx_inhibit && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (rx_inhibit) fail("wait_idle_timeout");
    repeat (4) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input int mode, input bit ovr);
    exp_end_t ex;
    logic [4:0] st;
    int n;
    wr(3'd1, 32'h1E);
    if (mode != M_SILENT) exp_bits_q.push_back(frame_bits(b));
    st = 5'h02;
    if (mode == M_NACK)   st |= 5'h04;
    if (mode == M_SILENT) st |= 5'h08;
    if (ovr)              st |= 5'h10;
    ex.status = st;
    ex.irq    = m_irq_en;
    exp_end_q.push_back(ex);
    dev_mode = mode;
    wr(3'd0, {24'd0, b});
    n = 0;
    while (!ps2_clk_oe && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ps2_clk_oe) fail("clk_oe_not_asserted");
    else begin
      n = 0;
      while (ps2_clk_oe && n < 1000) begin
        n++;
        @(negedge clk);
      end
      check("inhibit_plus_rts_cycles", 32'(n), 32'd121);
    end
    if (mode == M_SILENT) begin
      n = 0;
      while (rx_inhibit && n < 20000) begin
        @(negedge clk);
        n++;
      end
      check("start_timeout_cycles", 32'(n), 32'd15000);
    end
    if (ovr) begin
      repeat (200) @(negedge clk);
      wr(3'd0, 32'h55);
    end
    wait_idle(5000);
    rd_check("last_byte", 3'd0, {24'd0, b});
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n;
    logic [7:0] rb;
    int rmode;
    bit ren;

    repeat (3) @(negedge clk);
    check("reset_status", spo, 32'd0);
    check("reset_oe", 32'({ps2_clk_oe, ps2_data_oe, irq, rx_inhibit}), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rd_check("reset_data", 3'd0, 32'd0);
    rd_check("reset_ctrl", 3'd2, 32'd0);
    rd_check("unmapped_read", 3'd5, 32'd0);

    wr(3'd2, 32'd1); m_irq_en = 1'b1;
    rd_check("ctrl_readback", 3'd2, 32'd1);
    send(8'hED, M_ACK, 1'b0);

    wr(3'd2, 32'd0); m_irq_en = 1'b0;
    send(8'h01, M_ACK, 1'b0);
    send(8'hFF, M_ACK, 1'b0);

    send(8'hA7, M_NACK, 1'b0);

    wr(3'd2, 32'd1); m_irq_en = 1'b1;
    send(8'h3C, M_SILENT, 1'b0);

    send(8'hED, M_ACK, 1'b1);
    wr(3'd1, 32'h1E);
    rd_check("status_cleared", 3'd1, 32'd0);
    check("irq_cleared", 32'(irq), 32'd0);

    for (int i = 0; i < 6; i++) begin
      rb    = 8'($urandom);
      rmode = int'($urandom_range(0, 1));
      ren   = 1'($urandom_range(0, 1));
      wr(3'd2, 32'(ren)); m_irq_en = ren;
      send(rb, rmode, 1'b0);
    end

    wr(3'd1, 32'h1E);
    dev_mode = M_ACK;
    dev_edge = 0;
    wr(3'd0, 32'hA5);
    n = 0;
    while (dev_edge != 5 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (dev_edge != 5) fail("edge5_not_reached");
    repeat (10) @(negedge clk);
    #2;
    rst = 1'b0;
    dev_abort = 1'b1;
    #1;
    check("reset_async_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    check("reset_mid_status", spo, 32'd0);
    rd_check("reset_mid_data", 3'd0, 32'd0);
    rd_check("reset_mid_ctrl", 3'd2, 32'd0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    m_irq_en = 1'b0;
    n = 0;
    while (dev_busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (dev_busy) fail("device_abort_wait");
    dev_abort = 1'b0;
    repeat (5) @(negedge clk);
    send(8'h5A, M_ACK, 1'b0);

    repeat (10) @(negedge clk);
    check("bits_queue_drained", 32'(exp_bits_q.size()), 32'd0);
    check("end_queue_drained", 32'(exp_end_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
